kbd_seq_encoder: RTL and testbench



---
 rtl/kbd_seq_pkg.sv | 63 ++++++
 rtl/kbd_seq_encoder_fifo.sv | 55 +++++
 rtl/kbd_seq_encoder.sv | 136 +++++++++++++
 tb/tb_kbd_seq_encoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_seq_pkg.sv
// Shared definitions for the keyboard-to-VT52 sequence encoder.
//   - key code constants for cursor and function keys
//   - control bytes (ESC, CR, LF)
//   - FSM state enum
//   - map_code(): raw key code -> {valid, two_byte, byte0, byte1}
package kbd_seq_pkg;

  localparam logic [7:0] KEY_UP    = 8'h80;
  localparam logic [7:0] KEY_DOWN  = 8'h81;
  localparam logic [7:0] KEY_RIGHT = 8'h82;
  localparam logic [7:0] KEY_LEFT  = 8'h83;
  localparam logic [7:0] KEY_F1    = 8'h84;
  localparam logic [7:0] KEY_F2    = 8'h85;
  localparam logic [7:0] KEY_F3    = 8'h86;
  localparam logic [7:0] KEY_F4    = 8'h87;

  localparam logic [7:0] ESC = 8'h1B;
  localparam logic [7:0] CR  = 8'h0D;
  localparam logic [7:0] LF  = 8'h0A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND1 = 2'd1,
    SEND2 = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       two_byte;
    logic [7:0] byte0;
    logic [7:0] byte1;
  } map_t;

  function automatic map_t map_code(input logic [7:0] code, input logic crlf);
    map_t m;
    m = '0;
    if (!code[7]) begin
      m.valid = 1'b1;
      m.byte0 = code;
      if (crlf && code == CR) begin
        m.two_byte = 1'b1;
        m.byte1    = LF;
      end
    end else begin
      m.valid    = 1'b1;
      m.two_byte = 1'b1;
      m.byte0    = ESC;
      case (code)
        KEY_UP:    m.byte1 = 8'h41;
        KEY_DOWN:  m.byte1 = 8'h42;
        KEY_RIGHT: m.byte1 = 8'h43;
        KEY_LEFT:  m.byte1 = 8'h44;
        KEY_F1:    m.byte1 = 8'h50;
        KEY_F2:    m.byte1 = 8'h51;
        KEY_F3:    m.byte1 = 8'h52;
        KEY_F4:    m.byte1 = 8'h53;
        default:   m = '0;  // 0x88-0xFF: no output
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/kbd_seq_encoder_fifo.sv
// Synchronous FIFO holding raw key codes.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   wr_en, din        push request and data
//   full              no free entry
//   rd_en, dout       pop request; dout is the head entry (combinational)
//   empty             no stored entry
// A push while full is accepted only if a pop happens in the same cycle,
// in which case the freed slot is the one written.
module kbd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);
  import kbd_seq_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // The extra pointer MSB separates full (MSBs differ) from empty (equal).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/kbd_seq_encoder.sv
// Keyboard key-code to VT52 byte-stream encoder.
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   usb_kbd          raw key code, stable while kbd_strobe is high
//   kbd_strobe       key event strobe, may be asynchronous to clk
//   m_tdata/m_tvalid/m_tready  byte stream towards the UART
//   overflow         one-cycle pulse when a key is dropped (FIFO full)
//
// state | meaning
// IDLE  | nothing presented; pop FIFO head if any
// SEND1 | first byte presented, waiting for handshake
// SEND2 | second byte (ESC suffix or LF) presented, waiting for handshake
module kbd_seq_encoder #(
  parameter int DEPTH = 4,
  parameter bit CRLF  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] usb_kbd,
  input  logic       kbd_strobe,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       overflow
);
  import kbd_seq_pkg::*;

  logic       s1, s2, s3;
  logic       key_event;
  logic       fifo_full;
  logic       fifo_empty;
  logic       rd_en;
  logic [7:0] fifo_dout;

  state_t     state, state_n;
  logic [7:0] tdata_n;
  logic       tvalid_n;
  logic [7:0] byte1, byte1_n;
  logic       pend, pend_n;
  map_t       m;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= kbd_strobe;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign key_event = s2 && !s3;

  kbd_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (key_event),
    .din   (usb_kbd),
    .full  (fifo_full),
    .rd_en (rd_en),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  // A full FIFO still takes the key when the head is popped this cycle.
  always_ff @(posedge clk) begin
    if (reset) overflow <= 1'b0;
    else       overflow <= key_event && fifo_full && !rd_en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      m_tdata  <= 8'h00;
      m_tvalid <= 1'b0;
      byte1    <= 8'h00;
      pend     <= 1'b0;
    end else begin
      state    <= state_n;
      m_tdata  <= tdata_n;
      m_tvalid <= tvalid_n;
      byte1    <= byte1_n;
      pend     <= pend_n;
    end
  end

  always_comb begin
    state_n  = state;
    tdata_n  = m_tdata;
    tvalid_n = m_tvalid;
    byte1_n  = byte1;
    pend_n   = pend;
    rd_en    = 1'b0;
    m        = map_code(fifo_dout, CRLF);
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          rd_en = 1'b1;
          if (m.valid) begin
            tdata_n  = m.byte0;
            tvalid_n = 1'b1;
            byte1_n  = m.byte1;
            pend_n   = m.two_byte;
            state_n  = SEND1;
          end
        end
      end
      SEND1: begin
        if (m_tready) begin
          if (pend) begin
            tdata_n = byte1;
            pend_n  = 1'b0;
            state_n = SEND2;
          end else begin
            tvalid_n = 1'b0;
            state_n  = IDLE;
          end
        end
      end
      SEND2: begin
        if (m_tready) begin
          tvalid_n = 1'b0;
          state_n  = IDLE;
        end
      end
      default: begin
        tvalid_n = 1'b0;
        pend_n   = 1'b0;
        state_n  = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_kbd_seq_encoder.sv
module tb_kbd_seq_encoder;

  logic       clk;
  logic       reset;
  logic [7:0] usb_kbd;
  logic       kbd_strobe;
  logic       m_tready;
  logic [7:0] tdata0, tdata1;
  logic       tvalid0, tvalid1;
  logic       ovf0, ovf1;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       hold0 = 1'b0, hold1 = 1'b0;
  logic [7:0] hold_d0 = '0, hold_d1 = '0;
  int         ovf_cnt0 = 0, ovf_cnt1 = 0;

  kbd_seq_encoder #(.DEPTH(4), .CRLF(1'b0)) dut0 (
    .clk(clk), .reset(reset), .usb_kbd(usb_kbd), .kbd_strobe(kbd_strobe),
    .m_tdata(tdata0), .m_tvalid(tvalid0), .m_tready(m_tready), .overflow(ovf0)
  );

  kbd_seq_encoder #(.DEPTH(4), .CRLF(1'b1)) dut1 (
    .clk(clk), .reset(reset), .usb_kbd(usb_kbd), .kbd_strobe(kbd_strobe),
    .m_tdata(tdata1), .m_tvalid(tvalid1), .m_tready(m_tready), .overflow(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_byte(input int idx, input logic [7:0] d);
    logic [7:0] e;
    n_cmp++;
    if ((idx == 0 ? q0.size() : q1.size()) == 0) begin
      n_err++;
      $display("FAIL out%0d: unexpected byte 0x%02h, expected none", idx, d);
    end else begin
      e = (idx == 0) ? q0.pop_front() : q1.pop_front();
      if (d !== e) begin
        n_err++;
        $display("FAIL out%0d: got 0x%02h expected 0x%02h", idx, d, e);
      end
    end
  endtask

  // Monitor: inputs change just after posedge, so at negedge both the
  // handshake inputs and the registered outputs are settled.
  always @(negedge clk) begin
    if (reset) begin
      hold0 = 1'b0;
      hold1 = 1'b0;
    end else begin
      if (hold0) begin
        n_cmp++;
        if (!(tvalid0 && tdata0 == hold_d0)) begin
          n_err++;
          $display("FAIL hold0: valid=%0b data=0x%02h expected valid=1 data=0x%02h", tvalid0, tdata0, hold_d0);
        end
      end
      if (hold1) begin
        n_cmp++;
        if (!(tvalid1 && tdata1 == hold_d1)) begin
          n_err++;
          $display("FAIL hold1: valid=%0b data=0x%02h expected valid=1 data=0x%02h", tvalid1, tdata1, hold_d1);
        end
      end
      if (tvalid0 && m_tready) chk_byte(0, tdata0);
      if (tvalid1 && m_tready) chk_byte(1, tdata1);
      hold0   = tvalid0 && !m_tready;
      hold_d0 = tdata0;
      hold1   = tvalid1 && !m_tready;
      hold_d1 = tdata1;
      if (ovf0) ovf_cnt0++;
      if (ovf1) ovf_cnt1++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic [7:0] code);
    usb_kbd    = code;
    kbd_strobe = 1'b1;
    step(3);
    kbd_strobe = 1'b0;
    step(3);
  endtask

  task automatic push_both(input logic [7:0] b);
    q0.push_back(b);
    q1.push_back(b);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!(tvalid0 && tvalid1) && k < 50) begin
      step(1);
      k++;
    end
    chk({name, "_valid_timeout"}, {30'd0, tvalid1, tvalid0}, 32'd3);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while ((q0.size() != 0 || q1.size() != 0 || tvalid0 || tvalid1) && k < 200) begin
      step(1);
      k++;
    end
    chk({name, "_drain_q0"}, q0.size(), 0);
    chk({name, "_drain_q1"}, q1.size(), 0);
  endtask

  initial begin
    reset      = 1'b1;
    usb_kbd    = 8'h00;
    kbd_strobe = 1'b0;
    m_tready   = 1'b0;
    step(3);
    chk("rst_tvalid0", tvalid0, 0);
    chk("rst_tvalid1", tvalid1, 0);
    chk("rst_tdata0", tdata0, 8'h00);
    chk("rst_tdata1", tdata1, 8'h00);
    chk("rst_ovf0", ovf0, 0);
    chk("rst_ovf1", ovf1, 0);
    reset = 1'b0;
    step(2);

    // single key with latency check: strobe seen at edge 0, valid at edge 3
    m_tready = 1'b1;
    push_both(8'h41);
    usb_kbd    = 8'h41;
    kbd_strobe = 1'b1;
    step(3);
    chk("lat_edge2_valid", tvalid0, 0);
    step(1);
    chk("lat_edge3_valid", tvalid0, 1);
    chk("lat_edge3_data", tdata0, 8'h41);
    kbd_strobe = 1'b0;
    step(3);
    wait_drain("single");

    // arrow key under back-pressure
    m_tready = 1'b0;
    push_both(8'h1B);
    push_both(8'h41);
    send_key(8'h80);
    wait_valid("arrow");
    step(5);
    chk("arrow_held_data", tdata0, 8'h1B);
    chk("arrow_held_valid", tvalid0, 1);
    m_tready = 1'b1;
    wait_drain("arrow");

    // CR: plain on CRLF=0, CR LF on CRLF=1
    q0.push_back(8'h0D);
    q1.push_back(8'h0D);
    q1.push_back(8'h0A);
    send_key(8'h0D);
    wait_drain("crlf");

    // overflow: 0x30 in output reg, 0x31-0x34 fill FIFO, 0x35 dropped
    m_tready = 1'b0;
    ovf_cnt0 = 0;
    ovf_cnt1 = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) push_both(8'h30 + 8'(i));
      send_key(8'h30 + 8'(i));
    end
    step(4);
    chk("ovf_count0", ovf_cnt0, 1);
    chk("ovf_count1", ovf_cnt1, 1);
    chk("ovf_head0", tdata0, 8'h30);
    m_tready = 1'b1;
    wait_drain("ovf");

    // discarded code among mapped ones
    push_both(8'h1B);
    push_both(8'h53);
    push_both(8'h7A);
    send_key(8'h90);
    send_key(8'h87);
    send_key(8'h7A);
    wait_drain("discard");

    // reset after ESC of LEFT is accepted: 'D' must never appear
    m_tready = 1'b0;
    push_both(8'h1B);
    send_key(8'h83);
    wait_valid("rstmid");
    m_tready = 1'b1;
    step(1);
    m_tready = 1'b0;
    chk("rstmid_second", tdata0, 8'h44);
    reset = 1'b1;
    step(1);
    chk("rstmid_tvalid0", tvalid0, 0);
    chk("rstmid_tvalid1", tvalid1, 0);
    step(1);
    reset = 1'b0;
    chk("rstmid_q0_empty", q0.size(), 0);
    chk("rstmid_q1_empty", q1.size(), 0);
    m_tready = 1'b1;
    push_both(8'h31);
    send_key(8'h31);
    wait_drain("after_rst");
    step(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
